multdiv_sequencer: RTL
======================

# multdiv_sequencer

Multi-cycle controller for the processor's signed 32-bit multiply and divide. It latches the operands on a single-cycle start pulse and runs 32 iterations of shift-add (multiply) or restoring shift-subtract (divide) through one shared 33-bit adder/subtractor. It then presents the result with a one-cycle ready strobe. It sits beside the combinational ALU in the execute stage and signals exceptions to the stall/writeback logic.

## Interface
- No parameters; width fixed at 32.
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `ctrl_MULT`  in  1  one-cycle start pulse, signed multiply
- `ctrl_DIV`  in  1  one-cycle start pulse, signed divide
- `data_operandA`  in  32  multiplicand / dividend, two's complement
- `data_operandB`  in  32  multiplier / divisor, two's complement
- `data_result`  out  32  product low word or quotient; held until the next operation completes
- `data_exception`  out  1  valid only while `data_resultRDY`=1
- `data_resultRDY`  out  1  one-cycle completion strobe

## Operation
- States:
  - IDLE: waiting for a start pulse.
  - MULT, DIV: iteration counter runs 0..31.
  - DONE: one cycle; drives `data_resultRDY`, then returns to IDLE.
- Start:
  - A pulse sampled high latches A, B, op type, and result sign (sign(A) XOR sign(B) for both ops).
  - Latches |A| and |B| into the working registers and clears the counter.
- Multiply:
  - Unsigned 32 x 32 shift-add over 64 bits; negate at completion if the result sign is negative.
  - `data_result` = low 32 bits of the true signed product.
  - `data_exception`=1 if the product is outside [-2^31, 2^31-1], i.e. the top 33 bits of the 64-bit signed product are not all equal.
- Divide:
  - Restoring division on magnitudes; quotient truncates toward zero.
  - Negate the quotient if the result sign is negative. The remainder is discarded.
  - Divisor 0: `data_exception`=1, `data_result`=0.
  - -2^31 / -1: `data_exception`=1, `data_result`=0.
  - Exceptional divides take the full latency; no early exit.
- Start while busy (MULT/DIV/DONE): abort the current operation, latch the new operands, restart the counter. The aborted operation never asserts `data_resultRDY`.
- `ctrl_MULT` and `ctrl_DIV` high on the same edge: multiply wins.
- Operand changes after the start edge are ignored.
- Abs of -2^31 is computed as 33-bit magnitude 2^31. The adder is 33 bits wide for this reason.

## Timing
- Start pulse sampled at edge E0; iterations on edges E1..E32.
- `data_result`, `data_exception`, and `data_resultRDY` update at edge E33.
- `data_resultRDY` is high for exactly the cycle after E33, then drops at E34.
- Latency: 33 cycles from the start edge to the ready strobe, identical for all ops and exceptions.
- Back-to-back: a start pulse sampled in the DONE cycle is accepted, and its strobe follows 33 cycles later.
- `data_result` holds its last value between operations. `data_exception` is forced to 0 when `data_resultRDY`=0.
- Reset:
  - Effect: state IDLE, counter 0, `data_result`=0, `data_exception`=0, `data_resultRDY`=0.
  - Priority: overrides any start pulse on the same edge.
  - Mid-operation: aborts the operation; no strobe is produced.
  - First operation accepted: the first start pulse sampled after reset deasserts.

## Test plan
- Multiply: A=7, B=-3, pulse `ctrl_MULT` -> 33 cycles later `data_resultRDY`=1 for one cycle, `data_result`=0xFFFFFFEB, exception 0.
- Multiply overflow: A=0x00010000, B=0x00010000 -> `data_result`=0x00000000, `data_exception`=1. Then A=0x80000000, B=1 -> 0x80000000, exception 0.
- Divide: A=-100, B=7 -> `data_result`=0xFFFFFFF2 (-14), exception 0. Divide by zero (A=5, B=0) and A=0x80000000, B=-1 -> each gives result 0, exception 1, same 33-cycle latency.
- Restart:
  - Sequence: start MULT 6x7; at cycle 10 pulse `ctrl_DIV` with A=20, B=6.
  - Required: exactly one strobe, 33 cycles after the second pulse, result 3. Operands changed after the start do not alter results.
- Simultaneous and back-to-back:
  - `ctrl_MULT` and `ctrl_DIV` high together with A=9, B=3 -> result 27.
  - Pulse during the DONE cycle -> next strobe follows 33 cycles later.
- Reset: assert `reset` at cycle 15 of a divide -> outputs 0 next cycle, no strobe. A start pulse on the same edge as reset is ignored.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: 33-cycle signed 32-bit multiply/divide sharing one 33-bit adder.
module multdiv_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
    state_t state, state_next;
    logic [5:0]  count;
    logic [31:0] hi, lo, b, mag_a, mag_b, quo, fin_result;
    logic [32:0] add_x, add_y, sum;
    logic [63:0] prod;
    logic        neg, exc, start, busy, fin_exc;
    assign start = ctrl_MULT | ctrl_DIV;
    assign busy  = (state == MULT) || (state == DIV);
    assign mag_a = data_operandA[31] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[31] ? -data_operandB : data_operandB;
    // Multiply adds the multiplicand when the low bit is set; divide subtracts the divisor from the shifted remainder.
    always_comb begin
        add_x = (state == DIV) ? {hi, lo[31]} : {1'b0, hi};
        add_y = (state == DIV) ? ~{1'b0, b} : (lo[0] ? {1'b0, b} : 33'd0);
        sum   = add_x + add_y + {32'd0, state == DIV};
    end
    always_comb begin
        prod       = neg ? -{hi, lo} : {hi, lo};
        quo        = neg ? -lo : lo;
        fin_exc    = (state == MULT) ? ~(&prod[63:31] | ~|prod[63:31]) : ((b == 32'd0) | (~neg & lo[31]));
        fin_result = (state == MULT) ? prod[31:0] : (fin_exc ? 32'd0 : quo);
    end
    always_comb begin
        state_next = state;
        if (start)
            state_next = ctrl_MULT ? MULT : DIV;
        else if (state == DONE)
            state_next = IDLE;
        else if (busy && count == 6'd32)
            state_next = DONE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 6'd0;
            data_result <= 32'd0;
            exc         <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                count <= 6'd0;
                neg   <= data_operandA[31] ^ data_operandB[31];
                hi    <= 32'd0;
                lo    <= ctrl_MULT ? mag_b : mag_a;
                b     <= ctrl_MULT ? mag_a : mag_b;
            end else if (busy && count == 6'd32) begin
                data_result <= fin_result;
                exc         <= fin_exc;
            end else if (state == MULT) begin
                count <= count + 6'd1;
                hi    <= sum[32:1];
                lo    <= {sum[0], lo[31:1]};
            end else if (state == DIV) begin
                count <= count + 6'd1;
                hi    <= sum[32] ? add_x[31:0] : sum[31:0];
                lo    <= {lo[30:0], ~sum[32]};
            end
        end
    end
    assign data_resultRDY = (state == DONE);
    assign data_exception = (state == DONE) & exc;
endmodule
